// File: rtl/rf_wb_sequencer_if.sv
// Write-back sequencer bus.
// Groups the request handshake, the memory-read handshake, the register-file
// write port and the debug status outputs of rf_wb_sequencer.
//   slave  : the sequencer side (takes requests, drives the register file)
//   master : the decode/control + memory side (issues requests, returns data)
// rf_mux_src_t encoding used on req_src / rf_mux_src:
//   0 = RF_MUX_IMM, 1 = RF_MUX_ALU, 2 = RF_MUX_MEM, 3 = RF_MUX_R0
interface rf_wb_sequencer_if #(
  parameter int REG_ADDR_W = 3,
  parameter int CNT_W      = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic [1:0]            req_src;
  logic [REG_ADDR_W-1:0] req_dest;
  logic                  mem_rd_req;
  logic                  mem_rd_valid;
  logic [1:0]            rf_mux_src;
  logic                  rf_write_en;
  logic [REG_ADDR_W-1:0] rf_write_addr;
  logic                  done;
  logic                  timeout_err;
  logic [CNT_W-1:0]      wb_count;

  modport slave (
    input  req_valid, req_src, req_dest, mem_rd_valid,
    output req_ready, mem_rd_req, rf_mux_src, rf_write_en, rf_write_addr,
           done, timeout_err, wb_count
  );

  modport master (
    output req_valid, req_src, req_dest, mem_rd_valid,
    input  req_ready, mem_rd_req, rf_mux_src, rf_write_en, rf_write_addr,
           done, timeout_err, wb_count
  );
endinterface

// File: rtl/rf_wb_sequencer.sv
// Write-back sequencer for the register-file input mux.
// Accepts one write-back request (source + destination), fetches memory data
// first when the source is RF_MUX_MEM, then drives rf_mux_src, rf_write_en and
// rf_write_addr for exactly one cycle and counts the completed write-back.
// Ports:
//   clk   : system clock, rising edge
//   n_rst : asynchronous active-low reset
//   bus   : rf_wb_sequencer_if.slave (request, memory handshake, RF write
//           port, done / timeout_err pulses, wb_count)
// All bus outputs are registered.
module rf_wb_sequencer #(
  parameter int REG_ADDR_W  = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                n_rst,
  rf_wb_sequencer_if.slave    bus
);

  localparam logic [1:0] RF_MUX_IMM = 2'd0;
  localparam logic [1:0] RF_MUX_MEM = 2'd2;

  // Timer must be able to hold MEM_TIMEOUT-1.
  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEM_WAIT,
    S_WRITE
  } state_t;

  state_t                r_state;
  logic [TW-1:0]         r_timer;
  logic [REG_ADDR_W-1:0] r_dest;
  logic                  r_req_ready;
  logic                  r_mem_rd_req;
  logic [1:0]            r_rf_mux_src;
  logic                  r_rf_write_en;
  logic [REG_ADDR_W-1:0] r_rf_write_addr;
  logic                  r_done;
  logic                  r_timeout_err;
  logic [CNT_W-1:0]      r_wb_count;

  logic w_accept;
  assign w_accept = bus.req_valid && r_req_ready;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state         <= S_IDLE;
      r_timer         <= '0;
      r_dest          <= '0;
      r_req_ready     <= 1'b1;
      r_mem_rd_req    <= 1'b0;
      r_rf_mux_src    <= RF_MUX_IMM;
      r_rf_write_en   <= 1'b0;
      r_rf_write_addr <= '0;
      r_done          <= 1'b0;
      r_timeout_err   <= 1'b0;
      r_wb_count      <= '0;
    end else begin
      // Strobes default low; only the transitions below raise them.
      r_mem_rd_req  <= 1'b0;
      r_rf_write_en <= 1'b0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
      case (r_state)
        // WRITE lasts one cycle and accepts like IDLE so that non-MEM
        // requests stream at one write-back per cycle.
        S_IDLE, S_WRITE: begin
          if (w_accept) begin
            r_dest <= bus.req_dest;
            if (bus.req_src == RF_MUX_MEM) begin
              r_mem_rd_req <= 1'b1;
              r_timer      <= '0;
              r_req_ready  <= 1'b0;
              r_state      <= S_MEM_WAIT;
            end else begin
              r_rf_mux_src    <= bus.req_src;
              r_rf_write_addr <= bus.req_dest;
              r_rf_write_en   <= 1'b1;
              r_done          <= 1'b1;
              r_wb_count      <= r_wb_count + CNT_W'(1);
              r_req_ready     <= 1'b1;
              r_state         <= S_WRITE;
            end
          end else begin
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        S_MEM_WAIT: begin
          // Data arriving on the last allowed cycle still wins over the abort.
          if (bus.mem_rd_valid) begin
            r_rf_mux_src    <= RF_MUX_MEM;
            r_rf_write_addr <= r_dest;
            r_rf_write_en   <= 1'b1;
            r_done          <= 1'b1;
            r_wb_count      <= r_wb_count + CNT_W'(1);
            r_req_ready     <= 1'b1;
            r_state         <= S_WRITE;
          end else if (r_timer == TIMER_LAST) begin
            r_timeout_err <= 1'b1;
            r_req_ready   <= 1'b1;
            r_state       <= S_IDLE;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: begin
          r_req_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready     = r_req_ready;
  assign bus.mem_rd_req    = r_mem_rd_req;
  assign bus.rf_mux_src    = r_rf_mux_src;
  assign bus.rf_write_en   = r_rf_write_en;
  assign bus.rf_write_addr = r_rf_write_addr;
  assign bus.done          = r_done;
  assign bus.timeout_err   = r_timeout_err;
  assign bus.wb_count      = r_wb_count;

endmodule

// File: tb/tb_rf_wb_sequencer.sv
// Bench for rf_wb_sequencer. A 16-bit-counter instance and a 4-bit-counter
// instance see identical stimulus; expected write-backs / aborts are queued
// when stimulus is driven and popped when the DUT strobes rf_write_en or
// timeout_err.
module tb_rf_wb_sequencer;

  localparam logic [1:0] IMM = 2'd0;
  localparam logic [1:0] ALU = 2'd1;
  localparam logic [1:0] MEM = 2'd2;
  localparam logic [1:0] R0  = 2'd3;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  rf_wb_sequencer_if #(.REG_ADDR_W(3), .CNT_W(16)) bus ();
  rf_wb_sequencer_if #(.REG_ADDR_W(3), .CNT_W(4))  b4  ();

  rf_wb_sequencer #(.REG_ADDR_W(3), .MEM_TIMEOUT(15), .CNT_W(16)) dut (
    .clk(clk), .n_rst(n_rst), .bus(bus.slave)
  );
  rf_wb_sequencer #(.REG_ADDR_W(3), .MEM_TIMEOUT(15), .CNT_W(4)) dut4 (
    .clk(clk), .n_rst(n_rst), .bus(b4.slave)
  );

  assign b4.req_valid    = bus.req_valid;
  assign b4.req_src      = bus.req_src;
  assign b4.req_dest     = bus.req_dest;
  assign b4.mem_rd_valid = bus.mem_rd_valid;

  typedef struct {
    bit          is_to;
    logic [1:0]  src;
    logic [2:0]  dest;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] exp_cnt;
  int          n_chk  = 0;
  int          n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one request for a cycle; non-MEM requests queue their write now.
  task automatic req(input logic [1:0] src, input logic [2:0] dest);
    exp_t e;
    chk("req_ready_at_issue", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_src   = src;
    bus.req_dest  = dest;
    if (src != MEM) begin
      exp_cnt = exp_cnt + 16'd1;
      e = '{is_to: 1'b0, src: src, dest: dest, cnt: exp_cnt};
      sb.push_back(e);
    end
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic push_mem_write(input logic [2:0] dest);
    exp_t e;
    exp_cnt = exp_cnt + 16'd1;
    e = '{is_to: 1'b0, src: MEM, dest: dest, cnt: exp_cnt};
    sb.push_back(e);
  endtask

  task automatic do_reset();
    n_rst            = 1'b0;
    bus.req_valid    = 1'b0;
    bus.mem_rd_valid = 1'b0;
    sb.delete();
    exp_cnt = 16'd0;
    step();
    step();
    n_rst = 1'b1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"},  {31'd0, bus.req_ready},     32'd1);
    chk({tag, "_src"},    {30'd0, bus.rf_mux_src},    {30'd0, IMM});
    chk({tag, "_we"},     {31'd0, bus.rf_write_en},   32'd0);
    chk({tag, "_addr"},   {29'd0, bus.rf_write_addr}, 32'd0);
    chk({tag, "_mreq"},   {31'd0, bus.mem_rd_req},    32'd0);
    chk({tag, "_done"},   {31'd0, bus.done},          32'd0);
    chk({tag, "_terr"},   {31'd0, bus.timeout_err},   32'd0);
    chk({tag, "_cnt"},    {16'd0, bus.wb_count},      32'd0);
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (n_rst && (bus.rf_write_en || bus.timeout_err)) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_event", {30'd0, bus.rf_write_en, bus.timeout_err}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_kind", {30'd0, bus.rf_write_en, bus.timeout_err},
            e.is_to ? 32'd1 : 32'd2);
        chk("sb_cnt", {16'd0, bus.wb_count}, {16'd0, e.cnt});
        chk("sb_cnt4", {28'd0, b4.wb_count}, {28'd0, e.cnt[3:0]});
        if (!e.is_to) begin
          chk("sb_src",  {30'd0, bus.rf_mux_src},    {30'd0, e.src});
          chk("sb_addr", {29'd0, bus.rf_write_addr}, {29'd0, e.dest});
          chk("sb_done", {31'd0, bus.done},          32'd1);
        end
      end
    end
  end

  logic [1:0] b2b_src [3];
  logic [2:0] b2b_dest[3];

  initial begin
    n_rst            = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_src      = IMM;
    bus.req_dest     = 3'd0;
    bus.mem_rd_valid = 1'b0;
    exp_cnt          = 16'd0;
    #2;
    do_reset();
    chk_reset_vals("rst");

    // Single IMM write, one-cycle latency.
    req(IMM, 3'd3);
    chk("imm_we",   {31'd0, bus.rf_write_en},   32'd1);
    chk("imm_done", {31'd0, bus.done},          32'd1);
    chk("imm_addr", {29'd0, bus.rf_write_addr}, 32'd3);
    chk("imm_cnt",  {16'd0, bus.wb_count},      32'd1);
    step();
    chk("imm_we_drop", {31'd0, bus.rf_write_en}, 32'd0);

    // Back-to-back non-MEM requests.
    b2b_src  = '{ALU, R0, ALU};
    b2b_dest = '{3'd1, 3'd2, 3'd5};
    for (int i = 0; i < 3; i++) begin
      req(b2b_src[i], b2b_dest[i]);
      chk("b2b_we",    {31'd0, bus.rf_write_en},   32'd1);
      chk("b2b_addr",  {29'd0, bus.rf_write_addr}, {29'd0, b2b_dest[i]});
      chk("b2b_ready", {31'd0, bus.req_ready},     32'd1);
    end
    chk("b2b_cnt", {16'd0, bus.wb_count}, 32'd4);
    step();

    // MEM with data 3 cycles after mem_rd_req; a request during the wait is dropped.
    req(MEM, 3'd4);
    chk("mem_rdreq", {31'd0, bus.mem_rd_req}, 32'd1);
    chk("mem_ready", {31'd0, bus.req_ready},  32'd0);
    bus.req_valid = 1'b1; bus.req_src = IMM; bus.req_dest = 3'd7;
    step();
    bus.req_valid = 1'b0;
    chk("mem_rdreq_pulse", {31'd0, bus.mem_rd_req}, 32'd0);
    step();
    step();
    chk("mem_ready_wait", {31'd0, bus.req_ready}, 32'd0);
    bus.mem_rd_valid = 1'b1;
    push_mem_write(3'd4);
    step();
    bus.mem_rd_valid = 1'b0;
    chk("mem_we",   {31'd0, bus.rf_write_en}, 32'd1);
    chk("mem_src",  {30'd0, bus.rf_mux_src},  {30'd0, MEM});
    step();
    chk("mem_idle_we",    {31'd0, bus.rf_write_en}, 32'd0);
    chk("mem_idle_ready", {31'd0, bus.req_ready},   32'd1);
    // Stray mem_rd_valid while idle must not write.
    bus.mem_rd_valid = 1'b1;
    step();
    bus.mem_rd_valid = 1'b0;
    step();

    // MEM with no data: abort after 15 wait cycles.
    req(MEM, 3'd6);
    sb.push_back('{is_to: 1'b1, src: MEM, dest: 3'd6, cnt: exp_cnt});
    for (int k = 0; k < 15; k++) begin
      chk("to_wait_err", {31'd0, bus.timeout_err}, 32'd0);
      step();
    end
    chk("to_err", {31'd0, bus.timeout_err}, 32'd1);
    chk("to_we",  {31'd0, bus.rf_write_en}, 32'd0);
    chk("to_cnt", {16'd0, bus.wb_count},    {16'd0, exp_cnt});
    step();
    chk("to_err_pulse", {31'd0, bus.timeout_err}, 32'd0);
    chk("to_ready",     {31'd0, bus.req_ready},   32'd1);

    // Data on the last allowed cycle wins over the abort.
    req(MEM, 3'd6);
    for (int k = 0; k < 14; k++) step();
    bus.mem_rd_valid = 1'b1;
    push_mem_write(3'd6);
    step();
    bus.mem_rd_valid = 1'b0;
    chk("last_we",  {31'd0, bus.rf_write_en}, 32'd1);
    chk("last_err", {31'd0, bus.timeout_err}, 32'd0);
    step();

    // Asynchronous reset in MEM_WAIT; late data must not write.
    req(MEM, 3'd2);
    step();
    n_rst = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    sb.delete();
    exp_cnt = 16'd0;
    step();
    n_rst = 1'b1;
    bus.mem_rd_valid = 1'b1;
    step();
    bus.mem_rd_valid = 1'b0;
    step();
    chk("post_rst_we",  {31'd0, bus.rf_write_en}, 32'd0);
    chk("post_rst_cnt", {16'd0, bus.wb_count},    32'd0);

    // 17 write-backs: the 4-bit counter wraps to 1.
    do_reset();
    for (int i = 0; i < 17; i++) req(IMM, 3'(i));
    chk("wrap_cnt4",  {28'd0, b4.wb_count}, 32'd1);
    chk("wrap_cnt16", {16'd0, bus.wb_count}, 32'd17);
    step();
    step();
    chk("sb_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
